// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit seven-segment display with frame-synchronous
// input capture, inter-digit blanking and optional leading-zero suppression.
module seg7_scan_driver #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digit_val,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    input  logic        colon_in,
    output logic        dig3,
    output logic        dig2,
    output logic        dig1,
    output logic        dig0,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        e,
    output logic        f,
    output logic        g,
    output logic        colon,
    output logic        frame_start
);
    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

    logic [CW-1:0] r_slot_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_sh_val;
    logic [3:0]    r_sh_en;
    logic          r_sh_lz;
    logic          r_sh_colon;
    logic [3:0]    r_dig;
    logic [6:0]    r_seg;
    logic          r_colon;
    logic          r_frame_start;

    logic          w_capture;
    logic          w_slot_end;
    logic [3:0]    w_cur_val;
    logic [3:0]    w_zero;
    logic [3:0]    w_sup;
    logic          w_on;
    logic [6:0]    w_glyph;

    assign w_capture  = (r_idx == 2'd0) && (r_slot_cnt == '0);
    assign w_slot_end = (r_slot_cnt == CW'(SLOT_CYCLES - 1));
    assign w_cur_val  = r_sh_val[r_idx*4 +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (w_slot_end) begin
            r_slot_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_val   <= '0;
            r_sh_en    <= '0;
            r_sh_lz    <= 1'b0;
            r_sh_colon <= 1'b0;
        end else if (w_capture) begin
            r_sh_val   <= digit_val;
            r_sh_en    <= digit_en;
            r_sh_lz    <= lz_suppress;
            r_sh_colon <= colon_in;
        end
    end

    // A higher digit only blocks suppression if it is enabled and non-zero.
    always_comb begin
        for (int n = 0; n < 4; n++) w_zero[n] = (r_sh_val[n*4 +: 4] == 4'd0);
        w_sup[3] = r_sh_lz && w_zero[3];
        w_sup[2] = r_sh_lz && w_zero[2] && (w_zero[3] || !r_sh_en[3]);
        w_sup[1] = r_sh_lz && w_zero[1] && (w_zero[3] || !r_sh_en[3])
                           && (w_zero[2] || !r_sh_en[2]);
        w_sup[0] = 1'b0;
    end

    assign w_on = (r_slot_cnt >= CW'(BLANK_CYCLES)) && r_sh_en[r_idx] && !w_sup[r_idx];

    always_comb begin
        w_glyph = 7'b1111111;
        case (w_cur_val)
            4'h0: w_glyph = 7'b0000001;
            4'h1: w_glyph = 7'b1001111;
            4'h2: w_glyph = 7'b0010010;
            4'h3: w_glyph = 7'b0000110;
            4'h4: w_glyph = 7'b1001100;
            4'h5: w_glyph = 7'b0100100;
            4'h6: w_glyph = 7'b0100000;
            4'h7: w_glyph = 7'b0001111;
            4'h8: w_glyph = 7'b0000000;
            4'h9: w_glyph = 7'b0000100;
            4'hA: w_glyph = 7'b0001000;
            4'hB: w_glyph = 7'b1100000;
            4'hC: w_glyph = 7'b0110001;
            4'hD: w_glyph = 7'b1000010;
            4'hE: w_glyph = 7'b0110000;
            4'hF: w_glyph = 7'b0111000;
            default: w_glyph = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig         <= 4'd0;
            r_seg         <= 7'b1111111;
            r_colon       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_dig         <= w_on ? (4'b0001 << r_idx) : 4'b0000;
            r_seg         <= w_on ? w_glyph : 7'b1111111;
            r_colon       <= r_sh_colon;
            r_frame_start <= w_capture;
        end
    end

    assign {dig3, dig2, dig1, dig0} = r_dig;
    assign {a, b, c, d, e, f, g}    = r_seg;
    assign colon                    = r_colon;
    assign frame_start              = r_frame_start;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SLOT_CYCLES=8, BLANK_CYCLES=2.
module tb_seg7_scan_driver;
    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                           G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100,
                           G6 = 7'b0100000, G7 = 7'b0001111, G8 = 7'b0000000,
                           GE = 7'b0110000, OFF = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digit_val = '0;
    logic [3:0]  digit_en = '0;
    logic        lz_suppress = 1'b0;
    logic        colon_in = 1'b0;
    logic        dig3, dig2, dig1, dig0, a, b, c, d, e, f, g, colon, frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .digit_val(digit_val), .digit_en(digit_en),
        .lz_suppress(lz_suppress), .colon_in(colon_in),
        .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .colon(colon), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dig"},   {28'd0, dig3, dig2, dig1, dig0}, 32'd0);
        chk({tag, "_seg"},   {25'd0, a, b, c, d, e, f, g}, {25'd0, OFF});
        chk({tag, "_colon"}, {31'd0, colon}, 32'd0);
        chk({tag, "_fs"},    {31'd0, frame_start}, 32'd0);
    endtask

    // Restart from reset with the given inputs; the next posedge is edge 1.
    task automatic restart(input logic [15:0] v, input logic [3:0] en, input logic lz, input logic col);
        @(negedge clk);
        rst = 1'b1;
        digit_val = v; digit_en = en; lz_suppress = lz; colon_in = col;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Checks 32 edges (one frame). vis = which digits should light; gN = glyph of digit N.
    task automatic scan_frame(input string tag, input logic [3:0] vis,
                              input logic [6:0] g3, input logic [6:0] g2,
                              input logic [6:0] g1, input logic [6:0] g0,
                              input logic exp_col, input bit after_reset,
                              input int chg_at, input logic [15:0] chg_val);
        logic [6:0] gl [4];
        logic [3:0] edig;
        logic [6:0] eseg;
        gl[0] = g0; gl[1] = g1; gl[2] = g2; gl[3] = g3;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            edig = 4'd0;
            eseg = OFF;
            if ((i % 8) >= 2 && vis[i/8]) begin
                edig = 4'b0001 << (i / 8);
                eseg = gl[i/8];
            end
            chk({tag, "_dig"}, {28'd0, dig3, dig2, dig1, dig0}, {28'd0, edig});
            chk({tag, "_seg"}, {25'd0, a, b, c, d, e, f, g}, {25'd0, eseg});
            chk({tag, "_fs"}, {31'd0, frame_start}, {31'd0, (i == 0)});
            chk({tag, "_colon"}, {31'd0, colon}, {31'd0, (after_reset && i == 0) ? 1'b0 : exp_col});
            if (i + 1 == chg_at) digit_val = chg_val;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with random inputs
        digit_val = 16'($urandom); digit_en = 4'($urandom);
        lz_suppress = 1'($urandom); colon_in = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");

        // Basic scan with a mid-frame input change that must not tear frame 1
        restart(16'h4321, 4'hF, 1'b0, 1'b1);
        scan_frame("scan_f1", 4'hF, G4, G3, G2, G1, 1'b1, 1, 12, 16'h8765);
        scan_frame("scan_f2", 4'hF, G8, G7, G6, G5, 1'b1, 0, 0, 16'h0);
        scan_frame("scan_f3", 4'hF, G8, G7, G6, G5, 1'b1, 0, 0, 16'h0);

        // Async reset while dig2 is lit
        restart(16'h4321, 4'hF, 1'b0, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        chk("pre_rst_dig", {28'd0, dig3, dig2, dig1, dig0}, 32'h4);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        scan_frame("post_rst", 4'hF, G4, G3, G2, G1, 1'b1, 1, 0, 16'h0);

        // Leading-zero suppression
        restart(16'h0050, 4'hF, 1'b1, 1'b0);
        scan_frame("lz_0050", 4'b0011, OFF, OFF, G5, G0, 1'b0, 1, 0, 16'h0);
        restart(16'h0000, 4'hF, 1'b1, 1'b0);
        scan_frame("lz_0000", 4'b0001, OFF, OFF, OFF, G0, 1'b0, 1, 0, 16'h0);
        restart(16'h0050, 4'hF, 1'b0, 1'b0);
        scan_frame("nolz_0050", 4'hF, G0, G0, G5, G0, 1'b0, 1, 0, 16'h0);
        // Disabled non-zero higher digit does not block suppression
        restart(16'h9005, 4'b0111, 1'b1, 1'b1);
        scan_frame("lz_dis", 4'b0001, OFF, OFF, OFF, G5, 1'b1, 1, 0, 16'h0);

        // Enables and hex glyph
        restart(16'h000E, 4'b0001, 1'b0, 1'b0);
        scan_frame("en_E", 4'b0001, OFF, OFF, OFF, GE, 1'b0, 1, 0, 16'h0);

        // All enables off: dark display, frame_start keeps pulsing
        restart(16'h1234, 4'b0000, 1'b0, 1'b0);
        scan_frame("dark_f1", 4'b0000, OFF, OFF, OFF, OFF, 1'b0, 1, 0, 16'h0);
        scan_frame("dark_f2", 4'b0000, OFF, OFF, OFF, OFF, 1'b0, 0, 0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
